// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, sequencer
// states and the ALU/PC mux selects driven by the sequencer.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ST_IF   = 4'd0,
        ST_ID   = 4'd1,
        ST_EX   = 4'd2,
        ST_MRD  = 4'd3,
        ST_MWR  = 4'd4,
        ST_WB   = 4'd5,
        ST_WBL  = 4'd6,
        ST_BR   = 4'd7,
        ST_BRT  = 4'd8,
        ST_JMP  = 4'd9,
        ST_HALT = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10,
        SRCB_RSVD = 2'b11
    } alu_src_b_t;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle RV32I datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every enable, select and strobe.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_halted,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IF;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:  if (mem_ready) state_d = ST_ID;
            ST_ID: begin
                case (opcode)
                    OPC_RTYPE, OPC_IARITH,
                    OPC_LOAD, OPC_STORE:   state_d = ST_EX;
                    OPC_BRANCH:            state_d = ST_BR;
                    OPC_JAL, OPC_JALR:     state_d = ST_JMP;
                    OPC_SYSTEM:            state_d = ecall_halt ? ST_HALT : ST_IF;
                    default:               state_d = ST_IF;
                endcase
            end
            ST_EX: begin
                case (opcode)
                    OPC_RTYPE, OPC_IARITH: state_d = ST_WB;
                    OPC_LOAD:              state_d = ST_MRD;
                    OPC_STORE:             state_d = ST_MWR;
                    default:               state_d = ST_IF;
                endcase
            end
            ST_MRD:  if (mem_ready) state_d = ST_WBL;
            ST_MWR:  if (mem_ready) state_d = ST_IF;
            ST_BR:   state_d = alu_bcond ? ST_BRT : ST_IF;
            ST_WB, ST_WBL, ST_BRT, ST_JMP: state_d = ST_IF;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
    end

    // Everything is gated by reset so no write or strobe escapes while it is low.
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        mem_to_reg   = 1'b0;
        pc_source    = PCSRC_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = ALUOP_ADD;
        is_halted    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                ST_ID: begin
                    a_write      = 1'b1;
                    b_write      = 1'b1;
                    aluout_write = 1'b1;
                    alu_src_b    = SRCB_FOUR;
                    case (opcode)
                        OPC_RTYPE, OPC_IARITH, OPC_LOAD, OPC_STORE,
                        OPC_BRANCH, OPC_JAL, OPC_JALR: pc_write = 1'b0;
                        OPC_SYSTEM:                    pc_write = !ecall_halt;
                        default:                       pc_write = 1'b1;
                    endcase
                end
                ST_EX: begin
                    alu_src_a    = 1'b1;
                    aluout_write = 1'b1;
                    case (opcode)
                        OPC_RTYPE:  alu_op = ALUOP_RTYPE;
                        OPC_IARITH: begin
                            alu_src_b = SRCB_IMM;
                            alu_op    = ALUOP_ITYPE;
                        end
                        OPC_LOAD, OPC_STORE: alu_src_b = SRCB_IMM;
                        default: ;
                    endcase
                end
                ST_MRD: begin
                    i_or_d    = 1'b1;
                    mem_read  = 1'b1;
                    mdr_write = mem_ready;
                end
                ST_MWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                    end
                end
                ST_WB, ST_WBL: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (state_q == ST_WBL);
                    pc_write   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                end
                ST_BR: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_BRANCH;
                    pc_write  = !alu_bcond;
                    pc_source = alu_bcond ? PCSRC_ALU : PCSRC_ALUOUT;
                end
                ST_BRT: begin
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_JMP: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = (opcode == OPC_JALR);
                    alu_src_b = SRCB_IMM;
                end
                ST_HALT: is_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a per-instruction phase model
// predicts every cycle's outputs under randomized stalls and branch outcomes.
module tb_multicycle_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       alu_bcond, ecall_halt, mem_ready;
    logic       pc_write, ir_write, mdr_write, a_write, b_write, aluout_write, reg_write;
    logic       mem_read, mem_write, i_or_d, mem_to_reg, pc_source, alu_src_a, is_halted;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    multicycle_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .a_write(a_write), .b_write(b_write), .aluout_write(aluout_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .is_halted(is_halted), .state(state)
    );

    always #5 clk = ~clk;

    // Output vector: {state, halted, pcw, irw, mdrw, aw, bw, aluoutw, rw, mr, mw, iord, m2r, pcsrc, srca, srcb, aluop}
    localparam logic [21:0] HALTED = 22'h1 << 17, PCW = 22'h1 << 16, IRW = 22'h1 << 15;
    localparam logic [21:0] MDRW = 22'h1 << 14, AW = 22'h1 << 13, BW = 22'h1 << 12;
    localparam logic [21:0] ALW = 22'h1 << 11, RW = 22'h1 << 10, MR = 22'h1 << 9;
    localparam logic [21:0] MW = 22'h1 << 8, IOD = 22'h1 << 7, M2R = 22'h1 << 6;
    localparam logic [21:0] PCS = 22'h1 << 5, SRCA = 22'h1 << 4;
    localparam logic [21:0] B_FOUR = 22'h1 << 2, B_IMM = 22'h2 << 2;
    localparam logic [21:0] OP_BR = 22'h1, OP_R = 22'h2, OP_I = 22'h3;
    localparam logic [21:0] PC_PLUS4 = PCW | B_FOUR;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5;
    localparam int K_JALR = 6, K_ECALL = 7, K_UNK = 8, K_HALT = 9;

    typedef struct {
        int          mr;   // 0/1 forced, 2 = don't care (random)
        logic [21:0] v;
    } cyc_t;

    cyc_t q[$];
    int tests = 0, fails = 0;
    int pcw_seen, rw_seen;
    logic [6:0] next_opc;
    logic next_bc, next_eh;

    function automatic logic [21:0] obs();
        return {state, is_halted, pc_write, ir_write, mdr_write, a_write, b_write,
                aluout_write, reg_write, mem_read, mem_write, i_or_d, mem_to_reg,
                pc_source, alu_src_a, alu_src_b, alu_op};
    endfunction

    function automatic logic [21:0] st(input state_t s);
        return {s, 18'b0};
    endfunction

    function automatic logic [6:0] opc(input int kind);
        case (kind)
            K_R:            return OPC_RTYPE;
            K_I:            return OPC_IARITH;
            K_LOAD:         return OPC_LOAD;
            K_STORE:        return OPC_STORE;
            K_BR:           return OPC_BRANCH;
            K_JAL:          return OPC_JAL;
            K_JALR:         return OPC_JALR;
            K_ECALL, K_HALT: return OPC_SYSTEM;
            default:        return 7'b0001111;
        endcase
    endfunction

    function automatic void push(input int mr, input logic [21:0] v);
        cyc_t c;
        c.mr = mr;
        c.v  = v;
        q.push_back(c);
    endfunction

    // Instruction-level model: fetch, decode, then the phases the instruction class needs.
    function automatic void build(input int kind, input bit bc, input int s_if, input int s_mem);
        logic [21:0] dec;
        q.delete();
        for (int i = 0; i < s_if; i++) push(0, st(ST_IF) | MR);
        push(1, st(ST_IF) | MR | IRW);
        dec = st(ST_ID) | AW | BW | ALW | B_FOUR;
        if (kind == K_ECALL || kind == K_UNK) begin
            push(2, dec | PCW);
            return;
        end
        push(2, dec);
        case (kind)
            K_R: begin
                push(2, st(ST_EX) | SRCA | ALW | OP_R);
                push(2, st(ST_WB) | RW | PC_PLUS4);
            end
            K_I: begin
                push(2, st(ST_EX) | SRCA | ALW | B_IMM | OP_I);
                push(2, st(ST_WB) | RW | PC_PLUS4);
            end
            K_LOAD: begin
                push(2, st(ST_EX) | SRCA | ALW | B_IMM);
                for (int i = 0; i < s_mem; i++) push(0, st(ST_MRD) | IOD | MR);
                push(1, st(ST_MRD) | IOD | MR | MDRW);
                push(2, st(ST_WBL) | RW | M2R | PC_PLUS4);
            end
            K_STORE: begin
                push(2, st(ST_EX) | SRCA | ALW | B_IMM);
                for (int i = 0; i < s_mem; i++) push(0, st(ST_MWR) | IOD | MW);
                push(1, st(ST_MWR) | IOD | MW | PC_PLUS4);
            end
            K_BR: begin
                if (bc) begin
                    push(2, st(ST_BR) | SRCA | OP_BR);
                    push(2, st(ST_BRT) | PCW | B_IMM);
                end else begin
                    push(2, st(ST_BR) | SRCA | OP_BR | PCW | PCS);
                end
            end
            K_JAL:  push(2, st(ST_JMP) | RW | PCW | B_IMM);
            K_JALR: push(2, st(ST_JMP) | RW | PCW | B_IMM | SRCA);
            default: push(2, st(ST_HALT) | HALTED);
        endcase
    endfunction

    task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %06h expected %06h", tag, o, e);
        end
    endtask

    task automatic cycle(input int mr, input logic [21:0] e, input string tag);
        @(negedge clk);
        opcode     = next_opc;
        alu_bcond  = next_bc;
        ecall_halt = next_eh;
        mem_ready  = (mr == 2) ? 1'($urandom_range(0, 1)) : 1'(mr);
        #1;
        check(tag, obs(), e);
        pcw_seen += int'(pc_write);
        rw_seen  += int'(reg_write);
    endtask

    task automatic run_instr(input int kind, input bit bc, input int s_if, input int s_mem,
                             input string name);
        int rw_exp;
        next_opc = opc(kind);
        next_bc  = bc;
        next_eh  = (kind == K_HALT);
        build(kind, bc, s_if, s_mem);
        pcw_seen = 0;
        rw_seen  = 0;
        foreach (q[i]) cycle(q[i].mr, q[i].v, $sformatf("%s cyc%0d", name, i));
        rw_exp = (kind == K_R || kind == K_I || kind == K_LOAD || kind == K_JAL || kind == K_JALR) ? 1 : 0;
        check($sformatf("%s pc_write pulses", name), 22'(pcw_seen), (kind == K_HALT) ? 22'd0 : 22'd1);
        check($sformatf("%s reg_write pulses", name), 22'(rw_seen), 22'(rw_exp));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        reset     = 1'b1;
    endtask

    initial begin
        reset = 1'b0; opcode = '0; alu_bcond = 1'b0; ecall_halt = 1'b0; mem_ready = 1'b1;
        next_opc = '0; next_bc = 1'b0; next_eh = 1'b0;
        @(negedge clk);
        #1;
        check("reset outputs", obs(), '0);
        release_reset();

        run_instr(K_R, 1'b0, 0, 0, "add");
        run_instr(K_LOAD, 1'b0, 2, 2, "load_stall");
        run_instr(K_BR, 1'b0, 0, 0, "beq_nt");
        run_instr(K_BR, 1'b1, 0, 0, "beq_t");
        run_instr(K_JALR, 1'b0, 0, 0, "jalr");
        run_instr(K_JAL, 1'b0, 1, 0, "jal");
        run_instr(K_STORE, 1'b0, 0, 3, "store_stall");
        run_instr(K_ECALL, 1'b0, 0, 0, "ecall_cont");
        run_instr(K_UNK, 1'b0, 0, 0, "unknown");

        for (int n = 0; n < 40; n++)
            run_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $sformatf("rnd%0d", n));

        run_instr(K_HALT, 1'b0, 0, 0, "ecall_halt");
        for (int n = 0; n < 100; n++) begin
            next_opc = 7'($urandom);
            next_bc  = 1'($urandom_range(0, 1));
            next_eh  = 1'($urandom_range(0, 1));
            cycle(2, st(ST_HALT) | HALTED, $sformatf("halt hold%0d", n));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset from halt", obs(), '0);
        release_reset();

        // Abort a stalled store in MWR with reset.
        next_opc = OPC_STORE; next_bc = 1'b0; next_eh = 1'b0;
        cycle(1, st(ST_IF) | MR | IRW, "abort IF");
        cycle(2, st(ST_ID) | AW | BW | ALW | B_FOUR, "abort ID");
        cycle(2, st(ST_EX) | SRCA | ALW | B_IMM, "abort EX");
        cycle(0, st(ST_MWR) | IOD | MW, "abort MWR stall");
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b0;
        #1;
        check("reset in MWR", obs(), '0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("reset held", obs(), '0);
        release_reset();
        cycle(0, st(ST_IF) | MR, "post-abort IF");
        run_instr(K_R, 1'b0, 0, 0, "post-abort add");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
